// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : Instruction fetch stage with a single outstanding memory request,
//            a one-word skid buffer and a 2-bit bimodal branch predictor.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BR_INDEX_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  ex_redirect,
    input  logic [31:0]           ex_target,
    input  logic                  ex_upd_en,
    input  logic [BR_INDEX_W-1:0] ex_upd_index,
    input  logic                  ex_upd_taken,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_inst,
    output logic [BR_INDEX_W-1:0] if_br_index,
    output logic                  if_prd_jmp,
    output logic                  if_stall,
    output logic                  if_clear
);

    localparam int         c_bht_depth = 1 << BR_INDEX_W;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_fa;
    logic [31:0]           r_pend;
    logic [31:0]           r_ibuf;
    logic [31:0]           w_fa_nxt;
    logic [31:0]           w_pend_nxt;
    logic [31:0]           w_ibuf_nxt;
    logic [1:0]            r_bht [c_bht_depth];

    logic                  w_handoff;
    logic [31:0]           w_word;
    logic [BR_INDEX_W-1:0] w_lookup_idx;
    logic                  w_bht_taken;
    logic [31:0]           w_imm_j;
    logic [31:0]           w_imm_b;
    logic                  w_pred_taken;
    logic [31:0]           w_next_pc;

    // The delivered word comes from the skid buffer while holding, else straight from memory.
    assign w_word       = (r_state == S_HOLD) ? r_ibuf : mem_rdata;
    assign w_lookup_idx = r_fa[BR_INDEX_W+1:2];
    assign w_bht_taken  = r_bht[w_lookup_idx][1];
    assign w_imm_j      = {{11{w_word[31]}}, w_word[31], w_word[19:12], w_word[20],
                           w_word[30:21], 1'b0};
    assign w_imm_b      = {{19{w_word[31]}}, w_word[31], w_word[7], w_word[30:25],
                           w_word[11:8], 1'b0};

    always_comb begin
        w_pred_taken = 1'b0;
        w_next_pc    = r_fa + 32'd4;
        if (w_word[6:0] == c_op_jal) begin
            w_pred_taken = 1'b1;
            w_next_pc    = r_fa + w_imm_j;
        end else if ((w_word[6:0] == c_op_branch) && w_bht_taken) begin
            w_pred_taken = 1'b1;
            w_next_pc    = r_fa + w_imm_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Redirect always wins over a handoff; the acked word in a flush is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_fa_nxt    = r_fa;
        w_pend_nxt  = r_pend;
        w_ibuf_nxt  = r_ibuf;
        w_handoff   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                w_fa_nxt    = RESET_PC;
            end
            S_REQ: begin
                if (ex_redirect) begin
                    if (mem_ack) begin
                        w_fa_nxt    = ex_target;
                    end else begin
                        w_pend_nxt  = ex_target;
                        w_state_nxt = S_FLUSH;
                    end
                end else if (mem_ack) begin
                    if (stall_i) begin
                        w_ibuf_nxt  = mem_rdata;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_handoff   = 1'b1;
                        w_fa_nxt    = w_next_pc;
                    end
                end
            end
            S_HOLD: begin
                if (ex_redirect) begin
                    w_fa_nxt    = ex_target;
                    w_state_nxt = S_REQ;
                end else if (!stall_i) begin
                    w_handoff   = 1'b1;
                    w_fa_nxt    = w_next_pc;
                    w_state_nxt = S_REQ;
                end
            end
            S_FLUSH: begin
                if (mem_ack) begin
                    w_fa_nxt    = ex_redirect ? ex_target : r_pend;
                    w_state_nxt = S_REQ;
                end else if (ex_redirect) begin
                    w_pend_nxt  = ex_target;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fa   <= RESET_PC;
            r_pend <= 32'd0;
            r_ibuf <= 32'd0;
        end else begin
            r_fa   <= w_fa_nxt;
            r_pend <= w_pend_nxt;
            r_ibuf <= w_ibuf_nxt;
        end
    end

    // Reads above see the pre-update counter when lookup and update collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_bht_depth; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (ex_upd_en) begin
            if (ex_upd_taken) begin
                if (r_bht[ex_upd_index] != 2'b11) begin
                    r_bht[ex_upd_index] <= r_bht[ex_upd_index] + 2'd1;
                end
            end else if (r_bht[ex_upd_index] != 2'b00) begin
                r_bht[ex_upd_index] <= r_bht[ex_upd_index] - 2'd1;
            end
        end
    end

    always_comb begin
        mem_req     = (r_state == S_REQ) || (r_state == S_FLUSH);
        mem_addr    = r_fa;
        if_clear    = ex_redirect && (r_state != S_IDLE);
        if_stall    = !w_handoff;
        if_pc       = r_fa;
        if_inst     = w_word;
        if_br_index = w_lookup_idx;
        if_prd_jmp  = w_pred_taken;
        if (r_state == S_IDLE) begin
            mem_addr    = RESET_PC;
            if_pc       = 32'd0;
            if_inst     = 32'd0;
            if_br_index = '0;
            if_prd_jmp  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Directed bench for inst_fetch with a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int          W     = 6;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] ADDI  = 32'h0010_8093;   // addi x1,x1,1
    localparam logic [31:0] JAL40 = 32'h0400_006F;   // jal x0,+0x40
    localparam logic [31:0] BEQM8 = 32'hFE00_0CE3;   // beq x0,x0,-8

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_i;
    logic          ex_redirect;
    logic [31:0]   ex_target;
    logic          ex_upd_en;
    logic [W-1:0]  ex_upd_index;
    logic          ex_upd_taken;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic [31:0]   if_pc;
    logic [31:0]   if_inst;
    logic [W-1:0]  if_br_index;
    logic          if_prd_jmp;
    logic          if_stall;
    logic          if_clear;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RPC), .BR_INDEX_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .ex_upd_en    (ex_upd_en),
        .ex_upd_index (ex_upd_index),
        .ex_upd_taken (ex_upd_taken),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_br_index  (if_br_index),
        .if_prd_jmp   (if_prd_jmp),
        .if_stall     (if_stall),
        .if_clear     (if_clear)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h10) return JAL40;
        if (a == 32'h50) return BEQM8;
        return ADDI;
    endfunction

    always_comb mem_rdata = mem_ack ? imem(mem_addr) : 32'hDEAD_BEEF;

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: fetch pointer, optional buffered word, optional pending squash.
    bit          m_run;
    bit          m_buf_valid;
    bit          m_squash;
    logic [31:0] m_pc;
    logic [31:0] m_buf;
    logic [31:0] m_redir;
    int          m_bht [64];

    logic [31:0] hand_pc  [$];
    bit          hand_prd [$];
    logic [W-1:0] hand_idx [$];
    int          clr_cnt;

    always @(negedge clk) begin : compare
        logic [31:0] w;
        logic [31:0] nxt;
        logic [20:0] ij;
        logic [12:0] ib;
        bit          deliver;
        bit          prd;
        int          idx;
        if (!rst || !m_run) begin
            chk("idle_mem_req", 32'(mem_req), 32'd0);
            chk("idle_mem_addr", mem_addr, RPC);
            chk("idle_if_pc", if_pc, 32'd0);
            chk("idle_if_inst", if_inst, 32'd0);
            chk("idle_if_br_index", 32'(if_br_index), 32'd0);
            chk("idle_if_prd_jmp", 32'(if_prd_jmp), 32'd0);
            chk("idle_if_stall", 32'(if_stall), 32'd1);
            chk("idle_if_clear", 32'(if_clear), 32'd0);
            m_pc        = RPC;
            m_buf_valid = 1'b0;
            m_squash    = 1'b0;
            m_redir     = 32'd0;
            if (!rst) begin
                m_run = 1'b0;
                foreach (m_bht[i]) m_bht[i] = 1;
            end else begin
                m_run = 1'b1;
            end
        end else begin
            if (!if_stall) begin
                hand_pc.push_back(if_pc);
                hand_prd.push_back(if_prd_jmp);
                hand_idx.push_back(if_br_index);
            end
            if (if_clear) clr_cnt++;
            chk("mem_req", 32'(mem_req), 32'(!m_buf_valid));
            chk("mem_addr", mem_addr, m_pc);
            chk("if_clear", 32'(if_clear), 32'(ex_redirect));
            deliver = (m_buf_valid || (mem_ack && !m_squash)) && !stall_i && !ex_redirect;
            chk("if_stall", 32'(if_stall), 32'(!deliver));
            nxt = m_pc + 32'd4;
            if (deliver) begin
                w   = m_buf_valid ? m_buf : mem_rdata;
                idx = int'(m_pc[31:2]) % 64;
                prd = 1'b0;
                ij  = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                ib  = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                if (w[6:0] == 7'b1101111) begin
                    prd = 1'b1;
                    nxt = m_pc + 32'($signed(ij));
                end else if (w[6:0] == 7'b1100011 && m_bht[idx] >= 2) begin
                    prd = 1'b1;
                    nxt = m_pc + 32'($signed(ib));
                end
                chk("if_pc", if_pc, m_pc);
                chk("if_inst", if_inst, w);
                chk("if_br_index", 32'(if_br_index), 32'(idx));
                chk("if_prd_jmp", 32'(if_prd_jmp), 32'(prd));
            end
            if (m_squash) begin
                if (mem_ack) begin
                    m_squash = 1'b0;
                    m_pc     = ex_redirect ? ex_target : m_redir;
                end else if (ex_redirect) begin
                    m_redir = ex_target;
                end
            end else if (ex_redirect) begin
                if (m_buf_valid || mem_ack) begin
                    m_buf_valid = 1'b0;
                    m_pc        = ex_target;
                end else begin
                    m_squash = 1'b1;
                    m_redir  = ex_target;
                end
            end else if (deliver) begin
                m_buf_valid = 1'b0;
                m_pc        = nxt;
            end else if (mem_ack && !m_buf_valid) begin
                m_buf_valid = 1'b1;
                m_buf       = mem_rdata;
            end
            if (ex_upd_en) begin
                if (ex_upd_taken) m_bht[ex_upd_index] = (m_bht[ex_upd_index] == 3) ? 3 : m_bht[ex_upd_index] + 1;
                else              m_bht[ex_upd_index] = (m_bht[ex_upd_index] == 0) ? 0 : m_bht[ex_upd_index] - 1;
            end
        end
    end

    function automatic logic [31:0] qpc(input int i);
        if (i < hand_pc.size()) return hand_pc[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qprd(input int i);
        if (i < hand_prd.size()) return 32'(hand_prd[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qidx(input int i);
        if (i < hand_idx.size()) return 32'(hand_idx[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic void qclear();
        hand_pc.delete();
        hand_prd.delete();
        hand_idx.delete();
        clr_cnt = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; ex_redirect = 1'b0; ex_target = 32'd0;
        ex_upd_en = 1'b0; ex_upd_index = '0; ex_upd_taken = 1'b0; mem_ack = 1'b0;
        m_run = 1'b0; clr_cnt = 0;
        repeat (3) tick();

        // Zero-wait stream, JAL at 0x10, BEQ at 0x50 with reset BHT (updated in the lookup cycle).
        rst = 1'b1; mem_ack = 1'b1;
        repeat (6) tick();
        chk("lit_addr_after_jal", mem_addr, 32'h50);
        ex_upd_en = 1'b1; ex_upd_index = 6'h14; ex_upd_taken = 1'b1;
        repeat (2) tick();
        ex_upd_en = 1'b0;
        chk("lit_pc0", qpc(0), 32'h0);
        chk("lit_pc3", qpc(3), 32'hC);
        chk("lit_pc_jal", qpc(4), 32'h10);
        chk("lit_prd_jal", qprd(4), 32'd1);
        chk("lit_pc_beq", qpc(5), 32'h50);
        chk("lit_prd_beq_rst", qprd(5), 32'd0);
        chk("lit_pc_after_beq", qpc(6), 32'h54);

        // Re-fetch the BEQ after two taken updates.
        qclear();
        ex_redirect = 1'b1; ex_target = 32'h50;
        tick();
        ex_redirect = 1'b0;
        repeat (4) tick();
        chk("lit_beq_taken_pc", qpc(0), 32'h50);
        chk("lit_beq_taken_prd", qprd(0), 32'd1);
        chk("lit_beq_taken_idx", qidx(0), 32'h14);
        chk("lit_beq_target", qpc(1), 32'h48);
        chk("lit_clear_once_b", 32'(clr_cnt), 32'd1);

        // Three stall cycles with ack: word parks in the buffer, released when stall falls.
        qclear();
        stall_i = 1'b1;
        tick();
        #2 chk("lit_hold_no_req", 32'(mem_req), 32'd0);
        repeat (2) tick();
        chk("lit_no_hand_in_stall", 32'(hand_pc.size()), 32'd0);
        stall_i = 1'b0;
        #1 chk("lit_hold_release", 32'(if_stall), 32'd0);
        repeat (2) tick();

        // Redirect two cycles before a delayed ack.
        qclear();
        mem_ack = 1'b0;
        tick();
        ex_redirect = 1'b1; ex_target = 32'h200;
        tick();
        ex_redirect = 1'b0;
        #2 chk("lit_flush_req", 32'(mem_req), 32'd1);
        tick();
        mem_ack = 1'b1;
        repeat (3) tick();
        chk("lit_clear_once_d", 32'(clr_cnt), 32'd1);
        chk("lit_redirect_pc", qpc(0), 32'h200);

        // Redirects while flushing; the last one coincides with the ack.
        qclear();
        mem_ack = 1'b0; ex_redirect = 1'b1; ex_target = 32'h300;
        tick();
        ex_target = 32'h400;
        tick();
        ex_redirect = 1'b0;
        tick();
        mem_ack = 1'b1; ex_redirect = 1'b1; ex_target = 32'h500;
        tick();
        ex_redirect = 1'b0;
        repeat (2) tick();
        chk("lit_flush_ack_redirect", qpc(0), 32'h500);

        // Redirect while holding a buffered word.
        qclear();
        stall_i = 1'b1;
        tick();
        ex_redirect = 1'b1; ex_target = 32'h600;
        tick();
        ex_redirect = 1'b0; stall_i = 1'b0;
        repeat (2) tick();
        chk("lit_hold_redirect", qpc(0), 32'h600);

        // Reset mid-request: request withdrawn at once, BHT back to weakly not-taken.
        mem_ack = 1'b0;
        tick();
        rst = 1'b0;
        #1 chk("lit_rst_drops_req", 32'(mem_req), 32'd0);
        repeat (2) tick();
        qclear();
        rst = 1'b1; mem_ack = 1'b1;
        repeat (8) tick();
        chk("lit_rst_first_pc", qpc(0), RPC);
        chk("lit_rst_beq_pc", qpc(5), 32'h50);
        chk("lit_rst_beq_prd", qprd(5), 32'd0);
        chk("lit_rst_after_beq", qpc(6), 32'h54);

        // Mixed traffic; the model checks every cycle.
        for (int i = 0; i < 400; i++) begin
            mem_ack      = ($urandom_range(0, 2) != 0);
            stall_i      = ($urandom_range(0, 3) == 0);
            ex_redirect  = ($urandom_range(0, 11) == 0);
            ex_target    = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            ex_upd_en    = ($urandom_range(0, 2) == 0);
            ex_upd_index = 6'($urandom_range(16, 23));
            ex_upd_taken = ($urandom_range(0, 1) == 1);
            tick();
        end
        ex_redirect = 1'b0; ex_upd_en = 1'b0; stall_i = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter BR_INDEX_W, default 6: branch history table (BHT) index width; the BHT holds 2^BR_INDEX_W entries.
REQ-003 SHALL have ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- stall_i  input  1  downstream pipeline stall.
- ex_redirect  input  1  misprediction or redirect from EX.
- ex_target  input  32  redirect target address.
- ex_upd_en  input  1  BHT update strobe.
- ex_upd_index  input  BR_INDEX_W  BHT entry to update.
- ex_upd_taken  input  1  resolved branch outcome.
- mem_ack  input  1  instruction memory accepted the request; mem_rdata is valid this cycle.
- mem_rdata  input  32  fetched instruction word.
- mem_req  output  1  instruction memory request.
- mem_addr  output  32  request address.
- if_pc  output  32  PC of the delivered instruction.
- if_inst  output  32  delivered instruction.
- if_br_index  output  BR_INDEX_W  BHT index used for the prediction.
- if_prd_jmp  output  1  delivered instruction is predicted taken.
- if_stall  output  1  1 means there is no valid instruction this cycle; the IF/ID register holds.
- if_clear  output  1  flush the IF/ID register.

Function
REQ-004 SHALL implement states S_IDLE, S_REQ, S_HOLD and S_FLUSH, using registers fa (outstanding fetch address, 32 bits), pend (redirect target, 32 bits) and ibuf (instruction buffer, 32 bits).
REQ-005 SHALL leave S_IDLE for S_REQ on the first rising clk edge after rst deasserts, with fa = RESET_PC.
REQ-006 SHALL drive mem_req=1 in S_REQ and S_FLUSH and 0 otherwise; mem_addr SHALL equal fa.
REQ-007 SHALL hold mem_req and mem_addr stable until mem_ack; a request is never withdrawn.
REQ-008 SHALL hand off an instruction in two cases, each in the same cycle with zero added latency:
- S_REQ & mem_ack & !stall_i & !ex_redirect: if_inst=mem_rdata, if_stall=0.
- S_HOLD & !stall_i & !ex_redirect: if_inst=ibuf, if_stall=0.
- In both cases if_pc=fa.
REQ-009 SHALL, at a handoff, set fa <= next_pc and enter or stay in S_REQ.
REQ-010 SHALL, on S_REQ & mem_ack & stall_i & !ex_redirect, capture mem_rdata into ibuf and enter S_HOLD.
REQ-011 SHALL drive if_stall=1 in every cycle without a handoff.
REQ-012 SHALL compute next_pc from the delivered word w (opcode w[6:0]), with addresses wrapping modulo 2^32:
- 1101111 (JAL): fa + sext(immJ); if_prd_jmp=1.
- 1100011 (branch) with BHT[if_br_index][1]=1: fa + sext(immB); if_prd_jmp=1.
- otherwise: fa+4; if_prd_jmp=0.
REQ-013 SHALL drive if_br_index = fa[BR_INDEX_W+1:2].
REQ-014 SHALL hold a 2-bit saturating counter per BHT entry, with reset value 2'b01.
REQ-015 SHALL, when ex_upd_en=1, increment BHT[ex_upd_index] (saturating at 3) if ex_upd_taken=1, else decrement it (saturating at 0).
REQ-016 SHALL perform the BHT lookup using the pre-update counter value when an update and a lookup hit the same entry in the same cycle.
REQ-017 SHALL drive if_clear = ex_redirect in all states except S_IDLE; ex_redirect SHALL take priority over handoff, and no handoff occurs in that cycle.
REQ-018 SHALL handle redirect per state:
- S_REQ with mem_ack: fa <= ex_target; go to S_REQ.
- S_REQ without mem_ack: pend <= ex_target; go to S_FLUSH.
- S_HOLD: ibuf is discarded; fa <= ex_target; go to S_REQ.
- S_FLUSH: pend <= ex_target; stay in S_FLUSH.
REQ-019 SHALL, in S_FLUSH, discard the word returned with mem_ack and then set fa <= pend and go to S_REQ; a redirect arriving in that same ack cycle SHALL instead load fa from ex_target.
REQ-020 SHALL ignore stall_i in S_FLUSH.

Reset
REQ-021 SHALL, while rst=0, asynchronously force state=S_IDLE, fa=RESET_PC, pend=0, ibuf=0 and all BHT entries to 2'b01.
REQ-022 SHALL, while in S_IDLE, drive mem_req=0, mem_addr=RESET_PC, if_pc=0, if_inst=0, if_br_index=0, if_prd_jmp=0, if_stall=1 and if_clear=0.
REQ-023 SHALL, on reset asserted mid-request, abandon the outstanding request without waiting for mem_ack.

Verification
REQ-024 Zero-wait memory (mem_ack=1 every cycle), stall_i=0, ADDI stream -> one handoff per cycle; if_pc = 0, 4, 8, ...; if_stall=0 from the first S_REQ cycle onward.
REQ-025 Word at 0x10 is JAL with offset +0x40 -> if_prd_jmp=1 and the next mem_addr is 0x50; a BEQ at 0x50 with a reset-valued BHT -> if_prd_jmp=0 and the next mem_addr is 0x54.
REQ-026 Two ex_upd_en updates with taken=1 to index 0x14, then a BEQ at pc 0x50 with offset -8 -> if_prd_jmp=1, if_br_index=0x14, next mem_addr 0x48.
REQ-027 mem_ack returns with stall_i=1 for 3 cycles -> S_HOLD with mem_req=0; if_stall=1 for those 3 cycles; the buffered word is handed off in the cycle stall_i falls.
REQ-028 ex_redirect to 0x200 two cycles before a delayed mem_ack -> if_clear=1 for one cycle; mem_addr keeps the old address until ack; the acked word is dropped; the next request address is 0x200.
REQ-029 rst pulsed low mid-request -> mem_req drops immediately; the first request after release is to RESET_PC with all BHT entries back at 2'b01.
